eth_frame_builder: RTL and testbench
====================================

Name: eth_frame_builder

Overview:
- Upstream stage of the 10BASE-T Manchester transmitter.
- Assembles one fixed-length Ethernet frame into the shared 1 KiB frame BRAM, then hands it to the transmitter through its start/tx_busy handshake.
- Frame layout: 14-byte header (destination MAC, source MAC, EtherType) built from parameters, then a byte-stream payload, then zero padding.
- Every frame is exactly FRAME_LEN bytes, which matches the transmitter's fixed 512-byte read.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC; sent MSB byte first at address 0.
- SRC_MAC, 48'h020000000001, source MAC; bytes at addresses 6..11.
- ETHERTYPE, 16'h88B5, EtherType; high byte at 12, low byte at 13.
- FRAME_LEN, 512, total bytes written per frame; must be ≤ 2^ADDR_W.
- ADDR_W, 10, BRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  payload byte valid.
- in_data  in  8  payload byte.
- in_last  in  1  marks the final payload byte of the frame.
- in_ready  out  1  builder accepts in_data this cycle (accept = in_valid & in_ready).
- bram_wr_en  out  1  BRAM write strobe.
- bram_wr_addr  out  ADDR_W  BRAM write address.
- bram_wr_data  out  8  BRAM write data.
- tx_start  out  1  start request to transmitter (level, see handshake).
- tx_busy  in  1  transmitter busy (reading BRAM / sending).
- busy  out  1  high in any state other than IDLE.
- truncated  out  1  one-cycle pulse when payload exceeded capacity.
- frames_sent  out  16  count of frames handed off; wraps at 65535→0.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, address counter 0, frames_sent 0. A partial frame is discarded and the next frame restarts at address 0.
- Write outputs are registered. A write decided in cycle N appears on bram_wr_* in cycle N+1, with bram_wr_en high for exactly one cycle per byte.
- States:
  - IDLE: in_ready=0. Go to HEADER when in_valid=1 and tx_busy=0. The BRAM must never be written while tx_busy=1.
  - HEADER: write 14 header bytes to addresses 0..13, one per cycle, 14 cycles total. in_ready=0. Then go to PAYLOAD.
  - PAYLOAD: in_ready=1. Each accepted byte is written to the next address, starting at 14. in_valid gaps stall the address without writing.
    - Accept with in_last=1 at address < FRAME_LEN-1: go to PAD.
    - Accept at address FRAME_LEN-1 with in_last=1: go to START.
    - Accept at address FRAME_LEN-1 with in_last=0: go to DRAIN.
  - PAD: write 8'h00 to each remaining address through FRAME_LEN-1, one per cycle, in_ready=0. Then go to START.
  - DRAIN: in_ready=1, accepted bytes are discarded with no writes. On accepting in_last: pulse truncated for one cycle and go to START.
  - START: tx_start=1. tx_start is held high, because the transmitter samples start only on its clk_en. Go to WAIT_DONE on the first cycle tx_busy=1; tx_start drops that same cycle and frames_sent increments.
  - WAIT_DONE: tx_start=0. Go to IDLE when tx_busy=0.
- The address counter never exceeds FRAME_LEN-1; there is no wrap within a frame.
- Maximum payload = FRAME_LEN-14 = 498 bytes.
- If in_valid is asserted in IDLE while tx_busy=1: in_ready stays 0 and the byte is held upstream, not lost.
- A single-byte payload (in_last on the first byte) is legal: 1 byte is written, then 497 pad bytes.

Test Plan:
- 10-byte payload 0x01..0x0A, tx_busy model asserts 3 cycles after tx_start -> addresses 0..5=FF, 6..11=02 00 00 00 00 01, 12..13=88 B5, 14..23=01..0A, 24..511=00. Exactly 512 writes; tx_start is held until tx_busy=1; frames_sent=1.
- 498-byte payload with in_last on byte 498 -> last write at address 511, no PAD writes, truncated stays 0.
- 600-byte payload -> 498 bytes written (addr 14..511), 102 bytes accepted and discarded, truncated pulses once, no write address > 511.
- tx_busy=1 held while in_valid=1 in IDLE -> in_ready=0 and no bram_wr_en until tx_busy falls; the first header write follows within 2 cycles.
- Assert rst mid-PAYLOAD (at addr 100) -> all outputs 0 immediately; the next frame's first write is at address 0 and the header is complete.
- Random in_valid gaps (50% duty) with a 40-byte payload -> BRAM contents identical to the gap-free run; frames_sent increments per frame and wraps 65535→0.

Source files
------------

// File: rtl/eth_frame_builder.sv
// Builds one fixed-length Ethernet frame (header, payload, zero pad) into the frame BRAM,
// then hands it to the Manchester transmitter through the start/tx_busy handshake.
module eth_frame_builder #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [7:0]        bram_wr_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              truncated,
  output logic [15:0]       frames_sent
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] HDR_LAST  = ADDR_W'(13);
  localparam logic [111:0]      HDR       = {DST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {
    StIdle, StHeader, StPayload, StPad, StDrain, StStart, StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_d, trunc_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic [15:0]       frames_d;
  logic [111:0]      hdr_shift;

  // Header byte for the current address, MSB byte of the header first.
  assign hdr_shift = HDR << (8 * addr_q[3:0]);

  assign in_ready = (state_q == StPayload) || (state_q == StDrain);
  assign tx_start = (state_q == StStart);
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = addr_q;
    wr_data_d = 8'h00;
    trunc_d   = 1'b0;
    frames_d  = frames_sent;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !tx_busy) begin
          state_d = StHeader;
          addr_d  = '0;
        end
      end
      StHeader: begin
        wr_en_d   = 1'b1;
        wr_data_d = hdr_shift[111:104];
        addr_d    = addr_q + 1'b1;
        if (addr_q == HDR_LAST) state_d = StPayload;
      end
      StPayload: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          if (addr_q == LAST_ADDR) begin
            state_d = in_last ? StStart : StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
            if (in_last) state_d = StPad;
          end
        end
      end
      StPad: begin
        wr_en_d = 1'b1;
        if (addr_q == LAST_ADDR) state_d = StStart;
        else                     addr_d  = addr_q + 1'b1;
      end
      StDrain: begin
        if (in_valid && in_last) begin
          trunc_d = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        // Held until the transmitter picks it up on one of its clock enables.
        if (tx_busy) begin
          state_d  = StWaitDone;
          frames_d = frames_sent + 16'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= 8'h00;
      truncated    <= 1'b0;
      frames_sent  <= 16'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bram_wr_en   <= wr_en_d;
      bram_wr_addr <= wr_addr_d;
      bram_wr_data <= wr_data_d;
      truncated    <= trunc_d;
      frames_sent  <= frames_d;
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// Bench for eth_frame_builder: table of frame scenarios checked by a BRAM write scoreboard,
// plus hand-written sequences for the tx_busy hold-off and a mid-payload reset.
module tb_eth_frame_builder;
  localparam int FL = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       tx_busy = 1'b0;
  logic       in_ready, bram_wr_en, tx_start, busy, truncated;
  logic [9:0] bram_wr_addr;
  logic [7:0] bram_wr_data;
  logic [15:0] frames_sent;

  eth_frame_builder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .bram_wr_en  (bram_wr_en),
    .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .truncated   (truncated),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int len; bit gaps; int pre_busy; int exp_trunc; int snap;} vec_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         fails = 0;
  int         wr_cnt = 0;
  int         max_addr = 0;
  int         trunc_cnt = 0;
  int         exp_frames = 0;
  logic [7:0] mem [FL];
  logic [7:0] snap_mem [FL];
  logic [7:0] hdr_exp [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h88, 8'hB5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, bram_wr_en, 0);
    chk({tag, "_wr_addr"}, bram_wr_addr, 0);
    chk({tag, "_wr_data"}, bram_wr_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_truncated"}, truncated, 0);
    chk({tag, "_frames_sent"}, frames_sent, 0);
  endtask

  // Write monitor: every BRAM write is popped against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (truncated) trunc_cnt++;
      if (bram_wr_en) begin
        wr_cnt++;
        if (int'(bram_wr_addr) > max_addr) max_addr = int'(bram_wr_addr);
        if (int'(bram_wr_addr) < FL) mem[bram_wr_addr] = bram_wr_data;
        chk("no_write_while_tx_busy", tx_busy, 0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                   bram_wr_addr, bram_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bram_wr_addr, e.addr);
          chk("wr_data", bram_wr_data, e.data);
        end
      end
    end
  end

  // Drives one frame of len bytes (0x01, 0x02, ...) and models the expected writes.
  // stop_after >= 0 abandons the frame after that many accepted bytes.
  task automatic run_frame(input int len, input bit gaps, input int pre_busy,
                           input int stop_after, input int exp_trunc, input bit do_tx);
    int  a = 14;
    bit  drain = 1'b0;
    int  n;
    bit  seen;
    bit  held;
    wr_t dummy;
    wr_cnt = 0;
    max_addr = 0;
    trunc_cnt = 0;
    for (int k = 0; k < 14; k++) push(k, int'(hdr_exp[k]));
    for (int i = 0; i < len; i++) begin
      if (stop_after >= 0 && i == stop_after) begin
        in_valid = 1'b0;
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_data  = 8'(i + 1);
      in_last  = (i == len - 1);
      in_valid = 1'b1;
      if (i == 0 && pre_busy > 0) begin
        tx_busy = 1'b1;
        repeat (pre_busy) begin
          @(negedge clk);
          chk("held_in_ready", in_ready, 0);
          chk("held_no_write", bram_wr_en, 0);
        end
        tx_busy = 1'b0;
        seen = 1'b0;
        repeat (2) begin
          @(negedge clk);
          if (bram_wr_en) seen = 1'b1;
        end
        chk("hdr_write_after_busy_drop", seen, 1);
      end
      n = 0;
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        in_valid = 1'b0;
        return;
      end
      if (!drain) begin
        push(a, i + 1 & 8'hFF);
        if (a == FL - 1) drain = 1'b1;
        else begin
          a++;
          if (in_last) for (int k = a; k < FL; k++) push(k, 0);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!do_tx) return;
    n = 0;
    while (!tx_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", tx_start, 1);
    if (!tx_start) return;
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!tx_start) held = 1'b0;
    end
    chk("tx_start_held", held, 1);
    tx_busy = 1'b1;
    @(negedge clk);
    exp_frames = (exp_frames + 1) & 16'hFFFF;
    chk("tx_start_dropped", tx_start, 0);
    chk("frames_sent", frames_sent, exp_frames);
    repeat (4) @(negedge clk);
    chk("busy_in_wait_done", busy, 1);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("idle_after_tx", busy, 0);
    chk("write_count", wr_cnt, FL);
    chk("max_write_addr", max_addr, FL - 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("truncated_pulses", trunc_cnt, exp_trunc);
    while (exp_q.size() > 0) dummy = exp_q.pop_front();
  endtask

  vec_t vecs[7];
  int   diffs;

  initial begin
    vecs[0] = '{len: 10,  gaps: 1'b0, pre_busy: 0, exp_trunc: 0, snap: 0};
    vecs[1] = '{len: 498, gaps: 1'b0, pre_busy: 0, exp_trunc: 0, snap: 0};
    vecs[2] = '{len: 600, gaps: 1'b0, pre_busy: 0, exp_trunc: 1, snap: 0};
    vecs[3] = '{len: 1,   gaps: 1'b0, pre_busy: 0, exp_trunc: 0, snap: 0};
    vecs[4] = '{len: 40,  gaps: 1'b0, pre_busy: 6, exp_trunc: 0, snap: 0};
    vecs[5] = '{len: 40,  gaps: 1'b0, pre_busy: 0, exp_trunc: 0, snap: 1};
    vecs[6] = '{len: 40,  gaps: 1'b1, pre_busy: 0, exp_trunc: 0, snap: 2};

    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].len, vecs[v].gaps, vecs[v].pre_busy, -1, vecs[v].exp_trunc, 1'b1);
      if (vecs[v].snap == 1) begin
        for (int k = 0; k < FL; k++) snap_mem[k] = mem[k];
      end else if (vecs[v].snap == 2) begin
        diffs = 0;
        for (int k = 0; k < FL; k++) if (mem[k] !== snap_mem[k]) diffs++;
        chk("gap_run_matches_gapless", diffs, 0);
      end
      repeat (2) @(negedge clk);
    end

    // Abandon a frame with the next payload address at 100, then reset asynchronously.
    run_frame(200, 1'b0, 0, 86, 0, 1'b0);
    chk("busy_mid_payload", busy, 1);
    chk("in_ready_mid_payload", in_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    exp_q.delete();
    exp_frames = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(10, 1'b0, 0, -1, 0, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
